lfsr_rng_range: RTL and testbench
=================================

// Module: lfsr_rng_range
// PURPOSE
//   Parametrised Fibonacci-LFSR random source for game logic (AI move picks, spawn
//   timing, hit variance). Free-running LFSR exposes a raw value every cycle, plus a
//   req/rsp handshake that returns a uniform value in [0, req_range) via rejection
//   sampling. Supports runtime reseed and zero-lockup recovery.
// PARAMETERS
//   WIDTH      16       LFSR state width (>= OUT_BITS, >= 4)
//   TAPS       16'hB400 feedback mask; default is maximal x^16+x^14+x^13+x^11
//   SEED       16'h89D1 reset/recovery seed; a value of 0 is treated as 1
//   OUT_BITS   5        width of rand_raw, req_range and rsp_data
//   MAX_TRIES  8        rejection attempts before fallback (>= 1)
// PORTS
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   seed_load    in   1         synchronous reseed strobe
//   seed_in      in   WIDTH     new seed; 0 is replaced by SEED
//   rand_raw     out  OUT_BITS  lfsr[WIDTH-1 -: OUT_BITS], continuous
//   req_valid    in   1         draw request
//   req_ready    out  1         high only in IDLE
//   req_range    in   OUT_BITS  exclusive upper bound; 0 = full 2^OUT_BITS range
//   rsp_valid    out  1         result available
//   rsp_ready    in   1         consumer accepts result
//   rsp_data     out  OUT_BITS  drawn value
//   rsp_fallback out  1         result came from the fallback path
// BEHAVIOUR
//   - Reset (async, rst_n=0): lfsr=SEED (or 1 if SEED==0), FSM=IDLE,
//     rsp_valid=0, rsp_data=0, rsp_fallback=0, try counter=0.
//   - Each posedge: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. Advances
//     unconditionally, including during draws.
//   - seed_load=1: lfsr <= seed_in (or SEED if seed_in==0) instead of shifting.
//     Takes priority over shift and zero recovery. Legal in any FSM state; an
//     in-progress draw continues on the new sequence.
//   - Zero lockup: if lfsr==0 and no seed_load, next lfsr = SEED.
//   - FSM IDLE: req_ready=1. On req_valid, latch range and clear tries, then go
//     to DRAW.
//   - FSM DRAW: req_ready=0. Each cycle compute cand = rand_raw.
//       If range==0 or cand<range: rsp_data=cand, rsp_fallback=0, rsp_valid=1,
//       go to HOLD.
//       Else if tries==MAX_TRIES-1: rsp_data=range-1, rsp_fallback=1,
//       rsp_valid=1, go to HOLD.
//       Else tries++.
//   - FSM HOLD: rsp_data and rsp_fallback stable, rsp_valid=1. On rsp_ready,
//     rsp_valid=0 and go to IDLE. The next request is accepted no earlier than
//     the cycle after that.
//   - Latency: rsp_valid rises 1 cycle after request acceptance at best, and
//     after at most MAX_TRIES cycles.
//   - Comparisons are unsigned at OUT_BITS width; tries is $clog2(MAX_TRIES+1)
//     bits wide.
//   - Reset during DRAW or HOLD aborts the draw. The pending result is lost and
//     the FSM returns to IDLE.
// CONFIGURATION
//   LFSR_ENTROPY_MIX_EN defined:
//     - Adds input port entropy_in (1 bit), placed after rst_n.
//     - Feedback becomes ^(lfsr & TAPS) ^ entropy_in.
//     - entropy_in is synchronised internally through 2 flops before use; the
//       synchroniser resets to 0.
//     - Zero-lockup recovery is reachable only in this mode.
//   LFSR_ENTROPY_MIX_EN undefined:
//     - No port, no synchroniser.
//     - Sequence is purely deterministic from the seed.
// TESTING
//   1. Release reset, default params -> rand_raw=17 (0x89D1); after 1 clk lfsr=0x13A3
//      and rand_raw=2.
//   2. Free-run 65535 clks after reset -> lfsr returns to 0x89D1, never 0 in between.
//   3. 1000 draws with req_range=6, rsp_ready=1 -> all rsp_data in 0..5, each
//      value hit; rsp_fallback=0 whenever cand<6.
//   4. MAX_TRIES=1, seed_load seed_in=16'hFFFF, then req_range=1 -> rsp_valid
//      next cycle, rsp_data=0, rsp_fallback=1.
//   5. Hold rsp_ready=0 for 10 clks in HOLD -> rsp_data stable, req_ready=0;
//      req_valid pulses ignored.
//   6. seed_load with seed_in=0 -> lfsr=0x89D1. Assert rst_n=0 mid-DRAW ->
//      rsp_valid=0 and req_ready=1 immediately.

Source files
------------

// File: rtl/lfsr_rng_range.sv
// lfsr_rng_range: Fibonacci-LFSR random source with a req/rsp handshake that
// returns a uniform value in [0, req_range) by rejection sampling, falling back
// to req_range-1 after MAX_TRIES rejected candidates.
// Optional feature macro: LFSR_ENTROPY_MIX_EN (adds entropy_in, XORed into the
// feedback after a 2-flop synchroniser).
module lfsr_rng_range #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'h89D1,
  parameter int unsigned      OUT_BITS  = 5,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef LFSR_ENTROPY_MIX_EN
  input  logic                entropy_in,
`endif
  input  logic                seed_load,
  input  logic [WIDTH-1:0]    seed_in,
  output logic [OUT_BITS-1:0] rand_raw,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OUT_BITS-1:0] req_range,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [OUT_BITS-1:0] rsp_data,
  output logic                rsp_fallback
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam int unsigned      TW       = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0]    LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    HOLD
  } state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    lfsr, lfsr_next;
  logic                feedback;
  logic [OUT_BITS-1:0] range_q;
  logic [TW-1:0]       tries;
  logic                hit, exhausted;

`ifdef LFSR_ENTROPY_MIX_EN
  logic [1:0] ent_sync;

  // Two-flop synchroniser for the asynchronous entropy bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ent_sync <= '0;
    else        ent_sync <= {ent_sync[0], entropy_in};
  end

  assign feedback = (^(lfsr & TAPS)) ^ ent_sync[1];
`else
  assign feedback = ^(lfsr & TAPS);
`endif

  // Next LFSR value: reseed beats zero recovery, which beats the normal shift.
  always_comb begin
    lfsr_next = {lfsr[WIDTH-2:0], feedback};
    if (seed_load)          lfsr_next = (seed_in == '0) ? SEED_EFF : seed_in;
    else if (lfsr == '0)    lfsr_next = SEED_EFF;
  end

  // LFSR state register, free-running every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED_EFF;
    else        lfsr <= lfsr_next;
  end

  assign rand_raw  = lfsr[WIDTH-1 -: OUT_BITS];
  assign hit       = (range_q == '0) || (rand_raw < range_q);
  assign exhausted = (tries == LAST_TRY);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid)        state_next = DRAW;
      DRAW:    if (hit || exhausted) state_next = HOLD;
      HOLD:    if (rsp_ready)        state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // FSM handshake outputs.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == HOLD);
  end

  // Draw datapath: latch range, count rejections, capture the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_q      <= '0;
      tries        <= '0;
      rsp_data     <= '0;
      rsp_fallback <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            range_q <= req_range;
            tries   <= '0;
          end
        end
        DRAW: begin
          if (hit) begin
            rsp_data     <= rand_raw;
            rsp_fallback <= 1'b0;
          end else if (exhausted) begin
            rsp_data     <= range_q - OUT_BITS'(1);
            rsp_fallback <= 1'b1;
          end else begin
            tries <= tries + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_range.sv
// tb_lfsr_rng_range: scoreboard bench for lfsr_rng_range (default build plus a
// MAX_TRIES=1 instance for the immediate-fallback case).
module tb_lfsr_rng_range;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        seed_load, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fallback;
  logic [15:0] seed_in;
  logic [4:0]  rand_raw, req_range, rsp_data;

  logic        seed_load1, req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_fallback1;
  logic [15:0] seed_in1;
  logic [4:0]  rand_raw1, req_range1, rsp_data1;

  lfsr_rng_range dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LFSR_ENTROPY_MIX_EN
    .entropy_in(1'b0),
`endif
    .seed_load(seed_load), .seed_in(seed_in), .rand_raw(rand_raw),
    .req_valid(req_valid), .req_ready(req_ready), .req_range(req_range),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_fallback(rsp_fallback)
  );

  lfsr_rng_range #(.MAX_TRIES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef LFSR_ENTROPY_MIX_EN
    .entropy_in(1'b0),
`endif
    .seed_load(seed_load1), .seed_in(seed_in1), .rand_raw(rand_raw1),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_range(req_range1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_fallback(rsp_fallback1)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0] data;
    logic       fb;
  } exp_t;

  exp_t q[$];
  int   hist[32];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference LFSR: taps x^16+x^14+x^13+x^11 -> state bits 15,13,12,10.
  function automatic logic [15:0] mstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [15:0] model_l;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              model_l <= 16'h89D1;
    else if (seed_load)      model_l <= (seed_in == 16'h0000) ? 16'h89D1 : seed_in;
    else if (model_l == 0)   model_l <= 16'h89D1;
    else                     model_l <= mstep(model_l);
  end

  // Expected draw result when the request is accepted at the edge after l0.
  function automatic exp_t predict(input logic [15:0] l0, input logic [4:0] rng, input int maxt);
    exp_t       e;
    logic [15:0] l;
    logic [4:0]  c;
    l = mstep(l0);
    for (int i = 0; i < maxt; i++) begin
      c = l[15:11];
      if (rng == 5'd0 || c < rng) begin
        e.data = c;
        e.fb   = 1'b0;
        return e;
      end
      l = mstep(l);
    end
    e.data = rng - 5'd1;
    e.fb   = 1'b1;
    return e;
  endfunction

  // Monitor: pops the scoreboard whenever a response handshake is presented.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got data %0d with empty scoreboard", rsp_data);
      end else begin
        e = q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_fallback", rsp_fallback, e.fb);
      end
      hist[rsp_data]++;
    end
  end

  // Issue one request at a negedge; pushes the expected response.
  task automatic do_req(input logic [4:0] rng);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    q.push_back(predict(model_l, rng, 8));
    req_range = rng;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for rsp_valid within MAX_TRIES edges, then let the handshake happen.
  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_latency", int'(rsp_valid && n <= 8), 1);
    @(negedge clk);
  endtask

  initial begin
    int zero_seen, raw_bad;
    exp_t pend;
    logic [4:0] dirs[5];
    dirs = '{5'd0, 5'd1, 5'd31, 5'd16, 5'd2};

    rst_n = 1'b0;
    seed_load = 1'b0; seed_in = '0; req_valid = 1'b0; req_range = '0; rsp_ready = 1'b1;
    seed_load1 = 1'b0; seed_in1 = '0; req_valid1 = 1'b0; req_range1 = '0; rsp_ready1 = 1'b0;
    foreach (hist[i]) hist[i] = 0;

    repeat (2) @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_data", rsp_data, 0);
    check("reset_rsp_fallback", rsp_fallback, 0);
    check("reset_rand_raw", rand_raw, 17);

    rst_n = 1'b1;
    check("release_rand_raw", rand_raw, 17);
    @(negedge clk);
    check("first_step_lfsr", dut.lfsr, 16'h13A3);
    check("first_step_rand_raw", rand_raw, 2);

    // Full period: 65535 steps from the seed back to the seed.
    zero_seen = 0;
    raw_bad   = 0;
    repeat (65534) begin
      @(negedge clk);
      if (dut.lfsr == 16'h0000) zero_seen++;
      if (rand_raw != model_l[15:11]) raw_bad++;
    end
    check("period_no_zero", zero_seen, 0);
    check("period_raw_track", raw_bad, 0);
    check("period_return_seed", dut.lfsr, 16'h89D1);

    // Uniform draws in [0,6).
    foreach (hist[i]) hist[i] = 0;
    for (int k = 0; k < 1000; k++) begin
      do_req(5'd6);
      wait_rsp();
    end
    for (int v = 0; v < 6; v++) check($sformatf("range6_hit_%0d", v), int'(hist[v] > 0), 1);

    // Other ranges, including the full-range encoding 0.
    foreach (dirs[i]) begin
      do_req(dirs[i]);
      wait_rsp();
    end

    // Backpressure in HOLD: output stable, extra requests ignored.
    rsp_ready = 1'b0;
    do_req(5'd9);
    pend = q[0];
    for (int n = 0; n < 20 && !rsp_valid; n++) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("hold_rsp_data", rsp_data, pend.data);
      check("hold_req_ready", req_ready, 0);
      check("hold_rsp_valid", rsp_valid, 1);
      req_valid = (c % 2 == 0);
      req_range = 5'd3;
    end
    req_valid = 1'b0;
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_released_idle", req_ready, 1);
    check("hold_no_extra_draw", rsp_valid, 0);

    // MAX_TRIES=1 instance: all-ones seed forces immediate fallback.
    @(negedge clk);
    seed_in1 = 16'hFFFF;
    seed_load1 = 1'b1;
    @(negedge clk);
    seed_load1 = 1'b0;
    req_range1 = 5'd1;
    req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    check("mt1_draw_not_valid", rsp_valid1, 0);
    @(negedge clk);
    check("mt1_rsp_valid", rsp_valid1, 1);
    check("mt1_rsp_data", rsp_data1, 0);
    check("mt1_rsp_fallback", rsp_fallback1, 1);
    @(posedge clk);
    #1 rsp_ready1 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rsp_ready1 = 1'b0;
    check("mt1_back_idle", req_ready1, 1);

    // Zero reseed maps to the default seed.
    seed_in = 16'h0000;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed0_lfsr", dut.lfsr, 16'h89D1);
    check("seed0_rand_raw", rand_raw, 17);

    // Reset mid-DRAW aborts the draw.
    req_range = 5'd0;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    @(negedge clk);
    check("abort_held_rsp_valid", rsp_valid, 0);
    check("abort_held_rsp_data", rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    do_req(5'd6);
    wait_rsp();

    check("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
